hit_merge_fifo: RTL and testbench
=================================

# hit_merge_fifo

Downstream consumer of the rasterizer's dual sample-hit outputs. Each cycle it accepts up to two hit records (lane 0, then lane 1) and merges them in order into a single first-word-fall-through FIFO. It drains the FIFO one record per cycle to the shader/framebuffer side over a valid/ready handshake. The rasterizer has no stall input, so the block exports an almost-full level for upstream halt logic, and it counts and flags any records it drops.

## Interface

Parameters:
- SIGFIG, 24, bits per coordinate/colour field (from rast_params)
- AXIS, 3, coordinates per hit
- COLORS, 3, colour channels per hit
- DEPTH, 8, FIFO entries; power of two, at least 4
- AFULL_MARGIN, 2, free-slot threshold for almost_full_H; range 2..DEPTH-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- hit_R18S  in  AXIS x SIGFIG signed  lane-0 hit location
- color_R18U  in  COLORS x SIGFIG  lane-0 colour
- hit_valid_R18H  in  1  lane-0 valid
- hit_R18S_2  in  AXIS x SIGFIG signed  lane-1 hit location
- color_R18U_2  in  COLORS x SIGFIG  lane-1 colour
- hit_valid_R18H_2  in  1  lane-1 valid
- out_hit_S  out  AXIS x SIGFIG signed  head-entry location
- out_color_U  out  COLORS x SIGFIG  head-entry colour
- out_valid_H  out  1  head entry present
- out_ready_H  in  1  consumer accepts the head entry
- almost_full_H  out  1  count >= DEPTH-AFULL_MARGIN
- overflow_H  out  1  sticky; set when any record is dropped
- drop_count_U  out  16  records dropped, saturates at 16'hFFFF

## Operation

- Storage: DEPTH-entry array of hit_entry_t, with rd_ptr and wr_ptr of log2(DEPTH) bits and count of log2(DEPTH)+1 bits.
- Pop: occurs when out_valid_H and out_ready_H are both 1. rd_ptr advances by 1 modulo DEPTH.
- Push order: lane 0 before lane 1. With both lanes valid, lane 0 goes to wr_ptr and lane 1 to wr_ptr+1 (modulo DEPTH).
- Free slots this cycle: free = DEPTH - count + pop. A pop in the same cycle frees a slot for a push.
- Acceptance, in lane order:
  - lane 0 is accepted if free >= 1;
  - lane 1 is accepted if the slots still free after lane 0 are >= 1.
  - Each rejected valid record is dropped.
- Drop handling:
  - drop_count_U adds 1 or 2 per cycle as needed and saturates at 16'hFFFF.
  - overflow_H is set on the first drop and stays set until rst.
- Count update: count_next = count + pushes - pop.
- A cycle with only lane 1 valid pushes one entry into wr_ptr. Lane indices never leave gaps.
- Head outputs are combinational reads of mem[rd_ptr]:
  - out_valid_H = (count != 0);
  - out_hit_S and out_color_U hold don't-care values when out_valid_H is 0.
- almost_full_H is decoded from the registered count. It does not look ahead at current pushes.

## Timing

- Reset (rst=0, asynchronous):
  - count, rd_ptr, wr_ptr, drop_count_U and overflow_H go to 0;
  - out_valid_H=0, almost_full_H=0;
  - the array contents are not reset.
- A reset asserted mid-burst discards all entries immediately. There is no partial drain.
- Latency: a record pushed at edge N appears on the outputs after edge N, when out_valid_H=1 in cycle N+1. There is no fall-through within the push cycle itself.
- Throughput: sustained one pop per cycle; bursts of up to two pushes per cycle.
- Handshake:
  - while out_valid_H=1 and out_ready_H=0, the head fields stay stable;
  - out_ready_H is allowed high while the FIFO is empty and has no effect then.
- Full with a pop and two pushes in the same cycle: one push is accepted into the freed slot and the other is dropped.
- Pointer wrap is silent modulo DEPTH. The count distinguishes full from empty.

## Structure

- rast_params package additions:
  - typedef hit_entry_t, struct packed {hit S[AXIS]; color U[COLORS]}, width (AXIS+COLORS)*SIGFIG;
  - localparam HIT_FIFO_DEPTH = 8.
- One sub-module, hit_fifo_mem: a DEPTH x hit_entry_t register array with two write ports (addresses wa0/wa1 and enables) and one asynchronous read port. It has no reset.
- The top holds the pointer and count logic, the acceptance logic and the drop counters.

## Test plan

- Reset, then a single lane-0 hit (hit=(5,7,1), color=(0x10,0x20,0x30)) with out_ready_H=1. Expect out_valid_H=1 with the same fields for exactly one cycle, on cycle N+1.
- Both lanes valid for 3 cycles with out_ready_H=0 (records A0,B0,A1,B1,A2,B2). Expect count=6 and almost_full_H=1 (6 >= 8-2). With out_ready_H=1, expect pops in order A0,B0,A1,B1,A2,B2.
- Fill to 8 with out_ready_H=0, then present both lanes for one cycle. Expect 2 drops: drop_count_U=2, overflow_H=1, count remains 8, and the head is unchanged.
- Full FIFO, out_ready_H=1 and both lanes valid in the same cycle. Expect 1 pop, lane 0 accepted, lane 1 dropped; count stays 8 and drop_count_U increments by 1.
- Lane-1-only valid in alternating cycles, 20 records with out_ready_H toggling 1/0. Expect all 20 delivered in order, the pointers to wrap at least twice, and no drops.
- Assert rst=0 asynchronously mid-cycle while the FIFO holds 5 entries and overflow_H=1. Expect immediate out_valid_H=0, overflow_H=0 and drop_count_U=0. After release, the next push is delivered normally.

Source files
------------

// File: rtl/hit_merge_fifo_pkg.sv
// Shared rasterizer hit-record parameters and the packed entry layout used by the hit merge FIFO.
package hit_merge_fifo_pkg;
  localparam int SIGFIG         = 24;
  localparam int AXIS           = 3;
  localparam int COLORS         = 3;
  localparam int HIT_FIFO_DEPTH = 8;

  typedef struct packed {
    logic signed [AXIS-1:0][SIGFIG-1:0] hit;
    logic        [COLORS-1:0][SIGFIG-1:0] color;
  } hit_entry_t;
endpackage

// File: rtl/hit_fifo_mem.sv
// Unreset register array for the hit FIFO.
// It has two write ports and one combinational read port, so writes are visible on the cycle after the edge.
module hit_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 144,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [W-1:0]  wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [W-1:0]  wd1,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd = mem[ra];
endmodule

// File: rtl/hit_merge_fifo.sv
// Merges two rasterizer hit lanes, lane 0 first, into one FWFT FIFO that drains one record per cycle.
// Records that find no free slot are dropped, counted, and flagged, because the source cannot be stalled.
module hit_merge_fifo
  import hit_merge_fifo_pkg::*;
#(
  parameter int SIGFIG       = hit_merge_fifo_pkg::SIGFIG,
  parameter int AXIS         = hit_merge_fifo_pkg::AXIS,
  parameter int COLORS       = hit_merge_fifo_pkg::COLORS,
  parameter int DEPTH        = HIT_FIFO_DEPTH,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R18S,
  input  logic        [COLORS-1:0][SIGFIG-1:0] color_R18U,
  input  logic                                 hit_valid_R18H,
  input  logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R18S_2,
  input  logic        [COLORS-1:0][SIGFIG-1:0] color_R18U_2,
  input  logic                                 hit_valid_R18H_2,
  output logic signed [AXIS-1:0][SIGFIG-1:0]   out_hit_S,
  output logic        [COLORS-1:0][SIGFIG-1:0] out_color_U,
  output logic                                 out_valid_H,
  input  logic                                 out_ready_H,
  output logic                                 almost_full_H,
  output logic                                 overflow_H,
  output logic [15:0]                          drop_count_U
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = (AXIS + COLORS) * SIGFIG;

  logic [AW-1:0] rd_ptr, wr_ptr, wa1;
  logic [CW-1:0] count, free, free_after0;
  logic          pop, acc0, acc1, drop0, drop1, we0, we1;
  logic [1:0]    pushes, drops;
  logic [16:0]   drop_sum;
  logic [EW-1:0] wd0, wd1, rd_dat;

  assign out_valid_H   = (count != '0);
  assign pop           = out_valid_H & out_ready_H;
  assign almost_full_H = (count >= CW'(DEPTH - AFULL_MARGIN));

  // A same-cycle pop frees its slot for an incoming record.
  assign free        = CW'(DEPTH) - count + CW'(pop);
  assign acc0        = hit_valid_R18H & (free != '0);
  assign free_after0 = free - CW'(acc0);
  assign acc1        = hit_valid_R18H_2 & (free_after0 != '0);
  assign drop0       = hit_valid_R18H & ~acc0;
  assign drop1       = hit_valid_R18H_2 & ~acc1;
  assign pushes      = {1'b0, acc0} + {1'b0, acc1};
  assign drops       = {1'b0, drop0} + {1'b0, drop1};

  // The first accepted record always lands at wr_ptr, so a lone lane-1 hit leaves no gap.
  assign we0 = acc0 | acc1;
  assign wd0 = acc0 ? {hit_R18S, color_R18U} : {hit_R18S_2, color_R18U_2};
  assign we1 = acc0 & acc1;
  assign wa1 = wr_ptr + AW'(1);
  assign wd1 = {hit_R18S_2, color_R18U_2};

  assign drop_sum = {1'b0, drop_count_U} + 17'(drops);

  hit_fifo_mem #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_mem (
    .clk (clk),
    .we0 (we0),
    .wa0 (wr_ptr),
    .wd0 (wd0),
    .we1 (we1),
    .wa1 (wa1),
    .wd1 (wd1),
    .ra  (rd_ptr),
    .rd  (rd_dat)
  );

  assign {out_hit_S, out_color_U} = rd_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      drop_count_U <= '0;
      overflow_H   <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr + AW'(pop);
      wr_ptr       <= wr_ptr + AW'(pushes);
      count        <= count + CW'(pushes) - CW'(pop);
      drop_count_U <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (drops != 2'd0) overflow_H <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hit_merge_fifo.sv
// Directed bench for hit_merge_fifo: a stimulus process queues the expected records and a negedge monitor checks every pop.
module tb_hit_merge_fifo;
  import hit_merge_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R18S, hit_R18S_2, out_hit_S;
  logic        [COLORS-1:0][SIGFIG-1:0] color_R18U, color_R18U_2, out_color_U;
  logic hit_valid_R18H, hit_valid_R18H_2, out_valid_H, out_ready_H;
  logic almost_full_H, overflow_H;
  logic [15:0] drop_count_U;

  int checks = 0;
  int errors = 0;
  hit_entry_t exp_q[$];

  hit_merge_fifo dut (
    .clk(clk), .rst(rst),
    .hit_R18S(hit_R18S), .color_R18U(color_R18U), .hit_valid_R18H(hit_valid_R18H),
    .hit_R18S_2(hit_R18S_2), .color_R18U_2(color_R18U_2), .hit_valid_R18H_2(hit_valid_R18H_2),
    .out_hit_S(out_hit_S), .out_color_U(out_color_U), .out_valid_H(out_valid_H),
    .out_ready_H(out_ready_H), .almost_full_H(almost_full_H),
    .overflow_H(overflow_H), .drop_count_U(drop_count_U)
  );

  always #5 clk = ~clk;

  function automatic hit_entry_t mk(input int id);
    hit_entry_t e;
    e.hit[0]   = SIGFIG'(id * 3);
    e.hit[1]   = SIGFIG'(id + 100);
    e.hit[2]   = SIGFIG'(-id);
    e.color[0] = SIGFIG'(id * 16);
    e.color[1] = SIGFIG'(id * 16 + 1);
    e.color[2] = SIGFIG'(24'hABC000 + id);
    return e;
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Drive both lanes for one cycle, then return 1 time unit after the edge.
  task automatic step(input logic v0, input hit_entry_t e0, input logic v1, input hit_entry_t e1,
                      input logic rdy);
    hit_valid_R18H   = v0;
    {hit_R18S, color_R18U}     = e0;
    hit_valid_R18H_2 = v1;
    {hit_R18S_2, color_R18U_2} = e1;
    out_ready_H      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (out_valid_H && n < 32) begin
      step(1'b0, '0, 1'b0, '0, 1'b1);
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid_H && out_ready_H) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h expected nothing", {out_hit_S, out_color_U});
      end else begin
        if ({out_hit_S, out_color_U} != exp_q[0]) begin
          errors++;
          $display("FAIL pop_data: got %h expected %h", {out_hit_S, out_color_U}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    hit_entry_t t1;
    int n;
    hit_valid_R18H = 0; hit_valid_R18H_2 = 0; out_ready_H = 0;
    hit_R18S = '0; color_R18U = '0; hit_R18S_2 = '0; color_R18U_2 = '0;
    #12 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", out_valid_H, 0);
    check("rst_afull", almost_full_H, 0);
    check("rst_ovf", overflow_H, 0);
    check("rst_drops", drop_count_U, 0);

    // Single lane-0 hit, visible only on the cycle after its push edge.
    t1.hit[0] = 24'sd5; t1.hit[1] = 24'sd7; t1.hit[2] = 24'sd1;
    t1.color[0] = 24'h10; t1.color[1] = 24'h20; t1.color[2] = 24'h30;
    exp_q.push_back(t1);
    step(1'b1, t1, 1'b0, '0, 1'b1);
    check("t1_valid_n1", out_valid_H, 1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    check("t1_valid_n2", out_valid_H, 0);

    // Both lanes, three cycles, no consumer: A0,B0,A1,B1,A2,B2.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(10 + 2*i));
      exp_q.push_back(mk(11 + 2*i));
      step(1'b1, mk(10 + 2*i), 1'b1, mk(11 + 2*i), 1'b0);
      if (i == 1) check("t2_afull_at4", almost_full_H, 0);
    end
    check("t2_afull_at6", almost_full_H, 1);
    drain(n);
    check("t2_pops", n, 6);

    // Fill to 8, then both lanes with no pop: two drops, head unchanged.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(20 + 2*i));
      exp_q.push_back(mk(21 + 2*i));
      step(1'b1, mk(20 + 2*i), 1'b1, mk(21 + 2*i), 1'b0);
    end
    check("t3_afull", almost_full_H, 1);
    step(1'b1, mk(28), 1'b1, mk(29), 1'b0);
    check("t3_drops", drop_count_U, 2);
    check("t3_ovf", overflow_H, 1);
    check("t3_head_same", ({out_hit_S, out_color_U} == mk(20)), 1);

    // Full with pop: lane 0 takes the freed slot, lane 1 drops.
    exp_q.push_back(mk(30));
    step(1'b1, mk(30), 1'b1, mk(31), 1'b1);
    check("t4_drops", drop_count_U, 3);
    drain(n);
    check("t4_pops", n, 8);

    // Lane-1 only on alternating cycles with toggling ready; pointers wrap.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        exp_q.push_back(mk(40 + i/2));
        step(1'b0, '0, 1'b1, mk(40 + i/2), 1'b1);
      end else begin
        step(1'b0, '0, 1'b0, '0, 1'b0);
      end
    end
    drain(n);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_drops", drop_count_U, 3);

    // Five entries held, then an asynchronous reset mid-cycle.
    step(1'b1, mk(50), 1'b1, mk(51), 1'b0);
    step(1'b1, mk(52), 1'b1, mk(53), 1'b0);
    step(1'b1, mk(54), 1'b0, '0, 1'b0);
    check("t6_pre_ovf", overflow_H, 1);
    check("t6_pre_valid", out_valid_H, 1);
    hit_valid_R18H = 0; hit_valid_R18H_2 = 0;
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", out_valid_H, 0);
    check("t6_rst_ovf", overflow_H, 0);
    check("t6_rst_drops", drop_count_U, 0);
    check("t6_rst_afull", almost_full_H, 0);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mk(60));
    step(1'b1, mk(60), 1'b0, '0, 1'b1);
    check("t6_post_valid", out_valid_H, 1);
    drain(n);
    check("t6_post_pops", n, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
